// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and defaults for the 3x3 convolution stage
package conv_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int PIX_W    = 4;

  typedef enum logic [1:0] {
    KERNEL_IDENTITY = 2'd0,
    KERNEL_GAUSS    = 2'd1,
    KERNEL_LAPLACE  = 2'd2,
    KERNEL_INVERT   = 2'd3
  } kernel_e;

  typedef logic [PIX_W-1:0] pix_t;

  // [row][col]: row 0 = y-2, row 2 = y; col 0 = x-2, col 2 = x
  typedef pix_t [2:0][2:0] window_t;

endpackage

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - one video line of pixels, combinational read, synchronous write
module line_buffer import conv_pkg::*; #(
  parameter int DEPTH  = H_ACTIVE,
  parameter int WIDTH  = PIX_W,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  // Contents are never reset; the filter's border rule hides stale lines.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/conv3x3_filter.sv
// rtl/conv3x3_filter.sv - streaming 3x3 convolution, two line buffers, fixed two-cycle latency
module conv3x3_filter import conv_pkg::*; (
  input  logic             clk,
  input  logic             reset,
  input  logic             pixel_valid,
  input  logic [PIX_W-1:0] pixel_in,
  input  logic [9:0]       x_in,
  input  logic [9:0]       y_in,
  input  logic [1:0]       kernel_sel,
  output logic             out_valid,
  output logic [PIX_W-1:0] pixel_out,
  output logic [9:0]       x_out,
  output logic [9:0]       y_out
);

  localparam logic [9:0] H_LIMIT   = 10'(H_ACTIVE);
  localparam logic [7:0] PIX_MAX_8 = 8'((1 << PIX_W) - 1);

  function automatic pix_t k_gauss(window_t w);
    logic [7:0] s;
    s = 8'(w[0][0]) + 8'(w[0][2]) + 8'(w[2][0]) + 8'(w[2][2])
      + ((8'(w[0][1]) + 8'(w[1][0]) + 8'(w[1][2]) + 8'(w[2][1])) << 1)
      + (8'(w[1][1]) << 2);
    return pix_t'(s >> 4);
  endfunction

  function automatic pix_t k_laplace(window_t w);
    logic [7:0]        pos;
    logic [7:0]        neg;
    logic signed [7:0] d;
    logic [7:0]        mag;
    pos = 8'(w[1][1]) << 2;
    neg = 8'(w[0][1]) + 8'(w[2][1]) + 8'(w[1][0]) + 8'(w[1][2]);
    d   = $signed(pos - neg);
    mag = d[7] ? 8'(-d) : 8'(d);
    return (mag > PIX_MAX_8) ? '1 : pix_t'(mag);
  endfunction

  function automatic pix_t k_invert(window_t w);
    return {PIX_W{1'b1}} - w[1][1];
  endfunction

  function automatic pix_t apply_kernel(kernel_e k, window_t w);
    pix_t r;
    case (k)
      KERNEL_GAUSS:   r = k_gauss(w);
      KERNEL_LAPLACE: r = k_laplace(w);
      KERNEL_INVERT:  r = k_invert(w);
      default:        r = w[1][1];
    endcase
    return r;
  endfunction

  logic    take;
  logic    frame_start;
  logic    border;
  kernel_e kernel_now;
  pix_t    line1_rd;
  pix_t    line2_rd;

  window_t win;
  kernel_e kernel_active;
  logic    s0_valid;
  logic    s0_border;
  kernel_e s0_kernel;
  logic [9:0] s0_x;
  logic [9:0] s0_y;

  // Pixels past the active width are ignored entirely, not just unwritten.
  assign take        = pixel_valid && (x_in < H_LIMIT);
  assign frame_start = (x_in == 10'd0) && (y_in == 10'd0);
  assign border      = (x_in < 10'd2) || (y_in < 10'd2);
  assign kernel_now  = frame_start ? kernel_e'(kernel_sel) : kernel_active;

  line_buffer u_line1 (
    .clk     (clk),
    .wr_en   (take && reset),
    .addr    (x_in),
    .wr_data (pixel_in),
    .rd_data (line1_rd)
  );

  line_buffer u_line2 (
    .clk     (clk),
    .wr_en   (take && reset),
    .addr    (x_in),
    .wr_data (line1_rd),
    .rd_data (line2_rd)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      win           <= '0;
      kernel_active <= KERNEL_IDENTITY;
      s0_valid      <= 1'b0;
      s0_border     <= 1'b0;
      s0_kernel     <= KERNEL_IDENTITY;
      s0_x          <= '0;
      s0_y          <= '0;
      out_valid     <= 1'b0;
      pixel_out     <= '0;
      x_out         <= '0;
      y_out         <= '0;
    end else begin
      s0_valid <= take;
      if (take) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= line2_rd;
        win[1][2] <= line1_rd;
        win[2][2] <= pixel_in;
        s0_border <= border;
        s0_kernel <= kernel_now;
        s0_x      <= x_in;
        s0_y      <= y_in;
        if (frame_start) begin
          kernel_active <= kernel_e'(kernel_sel);
        end
      end

      out_valid <= s0_valid;
      if (s0_valid) begin
        pixel_out <= s0_border ? '0 : apply_kernel(s0_kernel, win);
        x_out     <= s0_x;
        y_out     <= s0_y;
      end
    end
  end

endmodule
